// File: rtl/fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_ctrl : IF-stage fetch controller. Credit-limited imem requests, an
//   in-order PC tag queue, and a small instruction buffer feeding ID.
//   Optional macro FETCH_BYPASS_EN: same-cycle response-to-ID bypass.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data,
  output logic            busy
);
  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_out, r_discard, r_buf_cnt;
  logic            r_hold, r_hold_stale;
  logic [XLEN-1:0] r_hold_addr;
  logic [PW-1:0]   r_tag_wp, r_tag_rp, r_buf_wp, r_buf_rp;
  logic [XLEN-1:0] r_tag_q    [DEPTH];
  logic [XLEN-1:0] r_buf_pc   [DEPTH];
  logic [XLEN-1:0] r_buf_data [DEPTH];

  logic            w_redir, w_credit, w_req_fire, w_fire_fresh, w_fire_stale;
  logic            w_rsp_take, w_rsp_drop, w_rsp_keep, w_byp;
  logic            w_pop, w_buf_push, w_buf_pop, w_hold_stale_nxt;
  logic [CW-1:0]   w_out_nxt, w_discard_nxt;
  logic            w_unused_lsb;

  assign w_unused_lsb = ^redirect_pc[1:0];

  assign w_redir        = redirect_valid && (r_state != S_BOOT);
  assign w_credit       = ({1'b0, r_out} + {1'b0, r_buf_cnt}) < C_DEPTH;
  // A request once raised is held (same address) until accepted.
  assign imem_req_valid = r_hold || ((r_state == S_RUN) && w_credit);
  assign imem_req_addr  = r_hold ? r_hold_addr : r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_fire_stale   = w_req_fire && (r_hold_stale || w_redir);
  assign w_fire_fresh   = w_req_fire && !w_fire_stale;

  assign w_rsp_take = imem_rsp_valid && (r_out != '0);
  assign w_rsp_drop = w_rsp_take && (r_discard != '0);
  assign w_rsp_keep = w_rsp_take && (r_discard == '0);

  assign w_out_nxt = r_out + CW'(w_req_fire) - CW'(w_rsp_take);
  // Stale responses are always the oldest in flight, so a count suffices.
  assign w_discard_nxt = w_redir ? w_out_nxt
                       : (r_discard + CW'(w_req_fire && r_hold_stale) - CW'(w_rsp_drop));
  assign w_hold_stale_nxt = w_req_fire ? 1'b0
                          : ((w_redir && imem_req_valid) ? 1'b1 : r_hold_stale);

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_rsp_keep && (r_state == S_RUN) && (r_buf_cnt == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign inst_valid = ((r_buf_cnt != '0) || w_byp) && !redirect_valid;

  always_comb begin
    inst_pc   = '0;
    inst_data = '0;
    if (w_byp) begin
      inst_pc   = r_tag_q[r_tag_rp];
      inst_data = imem_rsp_data;
    end else if (r_buf_cnt != '0) begin
      inst_pc   = r_buf_pc[r_buf_rp];
      inst_data = r_buf_data[r_buf_rp];
    end
  end

  assign w_pop      = inst_valid && inst_ready;
  assign w_buf_pop  = w_pop && !w_byp;
  assign w_buf_push = w_rsp_keep && !w_redir && !(w_byp && w_pop);
  assign busy       = (r_state == S_FLUSH) || (r_out != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:         w_state_nxt = S_RUN;
      S_RUN, S_FLUSH: w_state_nxt = ((w_discard_nxt != '0) || w_hold_stale_nxt) ? S_FLUSH : S_RUN;
      default:        w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_fetch_pc   <= RESET_PC;
      r_out        <= '0;
      r_discard    <= '0;
      r_hold       <= 1'b0;
      r_hold_stale <= 1'b0;
      r_hold_addr  <= RESET_PC;
      r_tag_wp     <= '0;
      r_tag_rp     <= '0;
      r_buf_wp     <= '0;
      r_buf_rp     <= '0;
      r_buf_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_out        <= w_out_nxt;
      r_discard    <= w_discard_nxt;
      r_hold       <= imem_req_valid && !imem_req_ready;
      r_hold_stale <= w_hold_stale_nxt;
      if (!r_hold) begin
        r_hold_addr <= imem_req_addr;
      end
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (w_fire_fresh) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_redir) begin
        r_tag_wp  <= '0;
        r_tag_rp  <= '0;
        r_buf_wp  <= '0;
        r_buf_rp  <= '0;
        r_buf_cnt <= '0;
      end else begin
        if (w_fire_fresh) r_tag_wp <= r_tag_wp + PW'(1);
        if (w_rsp_keep)   r_tag_rp <= r_tag_rp + PW'(1);
        if (w_buf_push)   r_buf_wp <= r_buf_wp + PW'(1);
        if (w_buf_pop)    r_buf_rp <= r_buf_rp + PW'(1);
        r_buf_cnt <= r_buf_cnt + CW'(w_buf_push) - CW'(w_buf_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire_fresh) begin
      r_tag_q[r_tag_wp] <= imem_req_addr;
    end
    if (w_buf_push) begin
      r_buf_pc[r_buf_wp]   <= r_tag_q[r_tag_rp];
      r_buf_data[r_buf_wp] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_ctrl : directed and randomized bench for fetch_ctrl against a
//   program-order PC stream model and an in-order latency memory model.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;
  localparam int unsigned    XW    = 32;
  localparam logic [XW-1:0]  RPC   = 32'h0000_0000;
  localparam int unsigned    DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int             LAT   = 1;
`else
  localparam int             LAT   = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [XW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [XW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [XW-1:0] imem_rsp_data = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [XW-1:0] inst_pc;
  logic [XW-1:0] inst_data;
  logic          busy;

  fetch_ctrl #(.XLEN(XW), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [XW-1:0] a; int due; } ment_t;
  ment_t         mq[$];
  logic [XW-1:0] fired[$];
  int            fired_cyc[$];
  logic [XW-1:0] deliv[$];
  int            deliv_cyc[$];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [XW-1:0] exp_pc;
  logic          prev_pend;
  logic [XW-1:0] prev_addr;
  logic          d_req_ready, d_inst_ready, d_redir, rsp_rand;
  logic [XW-1:0] d_redir_pc;
  int            lat_min, lat_max;
  logic          s_req_valid, s_inst_valid, s_busy;
  logic [XW-1:0] s_req_addr;

  function automatic logic [XW-1:0] mem_word(input logic [XW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [XW-1:0] fget(input int i);
    return (fired.size() > i) ? fired[i] : 'x;
  endfunction

  function automatic logic [XW-1:0] dget(input int i);
    return (deliv.size() > i) ? deliv[i] : 'x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_data", inst_data, 0);
    mq.delete(); fired.delete(); fired_cyc.delete(); deliv.delete(); deliv_cyc.delete();
    prev_pend = 1'b0; prev_addr = '0; exp_pc = RPC;
    d_req_ready = 1'b1; d_inst_ready = 1'b1; d_redir = 1'b0; d_redir_pc = '0;
    rsp_rand = 1'b0; lat_min = 1; lat_max = 1;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, check at negedge, update models after posedge.
  task automatic tick();
    logic rv, f, dl;
    rv = 1'b0;
    if (mq.size() > 0) rv = (mq[0].due <= cyc) && (!rsp_rand || ($urandom_range(0, 3) != 0));
    else if (rsp_rand) rv = ($urandom_range(0, 7) == 0);
    imem_rsp_valid = rv;
    imem_rsp_data  = (mq.size() > 0) ? mem_word(mq[0].a) : $urandom;
    imem_req_ready = d_req_ready;
    inst_ready     = d_inst_ready;
    redirect_valid = d_redir;
    redirect_pc    = d_redir_pc;
    @(negedge clk);
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_busy       = busy;
    f  = imem_req_valid && imem_req_ready;
    dl = inst_valid && inst_ready;
    if (d_redir) chk("redir_mask", 32'(inst_valid), 0);
    if (prev_pend) begin
      chk("hold_valid", 32'(imem_req_valid), 1);
      chk("hold_addr", imem_req_addr, prev_addr);
    end
    if (imem_req_valid) chk("req_align", 32'(imem_req_addr[1:0]), 0);
    if (mq.size() != 0) chk("busy_outstanding", 32'(busy), 1);
    if (dl) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      deliv.push_back(inst_pc);
      deliv_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    if (rv && (mq.size() > 0)) void'(mq.pop_front());
    if (f) begin
      mq.push_back('{a: s_req_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
      fired.push_back(s_req_addr);
      fired_cyc.push_back(cyc);
    end
    if (d_redir) exp_pc = {d_redir_pc[31:2], 2'b00};
    chk("credit", 32'(mq.size() <= DEPTH), 1);
    prev_pend = s_req_valid && !d_req_ready;
    prev_addr = s_req_addr;
    cyc++;
  endtask

  initial begin
    int lat_obs, bad;
    // Reset, BOOT cycle, sequential fetch with 1-cycle memory.
    do_reset();
    tick(); chk("boot_no_req", 32'(s_req_valid), 0);
    tick(); chk("first_req_valid", 32'(s_req_valid), 1);
    chk("first_req_addr", s_req_addr, RPC);
    repeat (10) tick();
    chk("t1_req0", fget(0), 32'h0); chk("t1_req1", fget(1), 32'h4); chk("t1_req2", fget(2), 32'h8);
    chk("t1_pc0", dget(0), 32'h0); chk("t1_pc1", dget(1), 32'h4); chk("t1_pc2", dget(2), 32'h8);
    lat_obs = (fired_cyc.size() > 0 && deliv_cyc.size() > 0) ? deliv_cyc[0] - fired_cyc[0] : -1;
    chk("t1_latency", 32'(lat_obs), 32'(LAT));

    // ID stall: credit caps accepted requests at DEPTH.
    do_reset();
    d_inst_ready = 1'b0;
    repeat (10) tick();
    chk("t2_fires", 32'(fired.size()), 2);
    chk("t2_req0", fget(0), 32'h0); chk("t2_req1", fget(1), 32'h4);
    chk("t2_stalled_valid", 32'(s_req_valid), 0);
    chk("t2_inst_valid", 32'(s_inst_valid), 1);
    d_inst_ready = 1'b1;
    repeat (8) tick();
    chk("t2_pc0", dget(0), 32'h0); chk("t2_pc1", dget(1), 32'h4); chk("t2_resume", fget(2), 32'h8);

    // Memory not ready: request held stable, single handshake.
    do_reset();
    tick();
    d_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_valid", 32'(s_req_valid), 1);
      chk("t3_hold_addr", s_req_addr, 32'h0);
    end
    d_req_ready = 1'b1;
    tick();
    chk("t3_one_fire", 32'(fired.size()), 1);
    chk("t3_fire_addr", fget(0), 32'h0);

    // Redirect with two requests in flight.
    do_reset();
    lat_min = 5; lat_max = 5;
    d_redir = 1'b1; d_redir_pc = 32'h10;
    tick();
    d_redir = 1'b0;
    for (int i = 0; i < 10 && fired.size() < 2; i++) tick();
    chk("t4_req0", fget(0), 32'h10); chk("t4_req1", fget(1), 32'h14);
    chk("t4_inflight", 32'(mq.size()), 2);
    d_redir = 1'b1; d_redir_pc = 32'h103;
    tick();
    d_redir = 1'b0; lat_min = 1; lat_max = 1;
    fired.delete(); deliv.delete();
    tick();
    chk("t4_busy", 32'(s_busy), 1);
    repeat (25) tick();
    chk("t4_next_req", fget(0), 32'h100);
    chk("t4_first_pc", dget(0), 32'h100);
    bad = 0;
    foreach (deliv[i]) if (deliv[i] == 32'h10 || deliv[i] == 32'h14) bad++;
    chk("t4_no_stale", 32'(bad), 0);

    // Redirect coincident with a delivery handshake.
    do_reset();
    d_inst_ready = 1'b0;
    for (int i = 0; i < 10 && !s_inst_valid; i++) tick();
    chk("t5_have_inst", 32'(s_inst_valid), 1);
    d_inst_ready = 1'b1; d_redir = 1'b1; d_redir_pc = 32'h200;
    tick();
    chk("t5_mask", 32'(s_inst_valid), 0);
    d_redir = 1'b0;
    deliv.delete();
    repeat (10) tick();
    chk("t5_first_pc", dget(0), 32'h200);

    // Fetch PC wrap at the top of the address space.
    do_reset();
    d_redir = 1'b1; d_redir_pc = 32'hFFFF_FFFC;
    tick();
    d_redir = 1'b0;
    fired.delete();
    repeat (6) tick();
    chk("t6_top", fget(0), 32'hFFFF_FFFC);
    chk("t6_wrap", fget(1), 32'h0);

    // Asynchronous reset with requests in flight.
    lat_min = 4; lat_max = 4;
    repeat (4) tick();
    do_reset();

    // Randomized traffic against the stream and memory models.
    rsp_rand = 1'b1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      d_req_ready  = ($urandom_range(0, 9) < 7);
      d_inst_ready = ($urandom_range(0, 3) != 0);
      d_redir      = ($urandom_range(0, 39) == 0);
      d_redir_pc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                 : 32'($urandom);
      tick();
    end
    d_redir = 1'b0; d_req_ready = 1'b1; d_inst_ready = 1'b1; rsp_rand = 1'b0;
    deliv.delete();
    repeat (30) tick();
    chk("drain_progress", 32'(deliv.size() >= 10), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
